// File: rtl/regfile_port_ctrl.sv
// Write-queue / strobe sequencer and read-port driver for a 4x8 dual-port 74670 register file.
// Registered reads forward queued and in-flight write data ahead of the file commit.
module regfile_port_ctrl #(
  parameter int STROBE_CYCLES = 1,
  parameter int QDEPTH        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req_valid,
  output logic       wr_req_ready,
  input  logic [1:0] wr_req_addr,
  input  logic [7:0] wr_req_data,
  input  logic [1:0] rdL_req_addr,
  input  logic [1:0] rdR_req_addr,
  output logic [7:0] rdL_q,
  output logic [7:0] rdR_q,
  output logic       busy,
  output logic       rf__wr_en,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic       rf__rdL_en,
  output logic       rf__rdR_en,
  output logic [1:0] rf_rdL_addr,
  output logic [1:0] rf_rdR_addr,
  input  logic [7:0] rf_rdL_data,
  input  logic [7:0] rf_rdR_data
);

  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic [1:0]     q_addr_q [QDEPTH];
  logic [7:0]     q_data_q [QDEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     fl_addr_q, fl_addr_d;
  logic [7:0]     fl_data_q, fl_data_d;
  logic           wr_en_n_q, wr_en_n_d;
  logic [1:0]     wa_q, wa_d;
  logic [7:0]     wd_q, wd_d;
  logic [7:0]     rdl_q, rdl_d;
  logic [7:0]     rdr_q, rdr_d;
  logic           rd_en_n_q;
  logic           push, pop;
  logic [PW-1:0]  idx;

  assign push = wr_req_valid && (count_q < CW'(QDEPTH));
  assign pop  = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fl_addr_d = fl_addr_q;
    fl_data_d = fl_data_q;
    wr_en_n_d = wr_en_n_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        wr_en_n_d = 1'b1;
        state_d   = pop ? ST_SETUP : ST_IDLE;
        if (pop) begin
          fl_addr_d = q_addr_q[rptr_q];
          fl_data_d = q_data_q[rptr_q];
          wa_d      = q_addr_q[rptr_q];
          wd_d      = q_data_q[rptr_q];
        end
      end
      ST_SETUP: begin
        state_d   = ST_STROBE;
        wr_en_n_d = 1'b0;
        cnt_d     = SCW'(STROBE_CYCLES - 1);
      end
      default: begin
        if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          wr_en_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
    endcase
  end

  // Priority rises through the loop: file data, then in-flight, then queued oldest-to-newest.
  always_comb begin
    idx   = '0;
    rdl_d = rf_rdL_data;
    rdr_d = rf_rdR_data;
    if (state_q != ST_IDLE) begin
      if (fl_addr_q == rdL_req_addr) rdl_d = fl_data_q;
      if (fl_addr_q == rdR_req_addr) rdr_d = fl_data_q;
    end
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (q_addr_q[idx] == rdL_req_addr) rdl_d = q_data_q[idx];
        if (q_addr_q[idx] == rdR_req_addr) rdr_d = q_data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_q[wptr_q] <= wr_req_addr;
      q_data_q[wptr_q] <= wr_req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      fl_addr_q <= '0;
      fl_data_q <= '0;
      wr_en_n_q <= 1'b1;
      wa_q      <= '0;
      wd_q      <= '0;
      rdl_q     <= '0;
      rdr_q     <= '0;
      rd_en_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      fl_addr_q <= fl_addr_d;
      fl_data_q <= fl_data_d;
      wr_en_n_q <= wr_en_n_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      rdl_q     <= rdl_d;
      rdr_q     <= rdr_d;
      rd_en_n_q <= 1'b0;
    end
  end

  assign wr_req_ready = (count_q < CW'(QDEPTH));
  assign busy         = (count_q != '0) || (state_q != ST_IDLE);
  assign rf__wr_en    = wr_en_n_q;
  assign rf_wr_addr   = wa_q;
  assign rf_wr_data   = wd_q;
  assign rdL_q        = rdl_q;
  assign rdR_q        = rdr_q;
  assign rf__rdL_en   = rd_en_n_q;
  assign rf__rdR_en   = rd_en_n_q;
  assign rf_rdL_addr  = rdL_req_addr;
  assign rf_rdR_addr  = rdR_req_addr;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: two instances (strobe 1 and 3) share stimulus, each with a
// schedule-based model of queue/strobe timing plus a behavioural 74670 file.
module tb_regfile_port_ctrl;

  typedef struct {
    int         acc;
    int         start;
    logic [1:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req_valid;
  logic [1:0] wr_req_addr;
  logic [7:0] wr_req_data;
  logic [1:0] rdL_req_addr;
  logic [1:0] rdR_req_addr;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S = (g == 0) ? 1 : 3;

    logic       ready, busy, wr_en_n, rdL_en, rdR_en;
    logic [1:0] wa, rla, rra;
    logic [7:0] wd, rdL_q, rdR_q, rld, rrd;

    regfile_port_ctrl #(.STROBE_CYCLES(S), .QDEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .wr_req_valid(wr_req_valid), .wr_req_ready(ready),
      .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .rdL_req_addr(rdL_req_addr), .rdR_req_addr(rdR_req_addr),
      .rdL_q(rdL_q), .rdR_q(rdR_q), .busy(busy),
      .rf__wr_en(wr_en_n), .rf_wr_addr(wa), .rf_wr_data(wd),
      .rf__rdL_en(rdL_en), .rf__rdR_en(rdR_en),
      .rf_rdL_addr(rla), .rf_rdR_addr(rra),
      .rf_rdL_data(rld), .rf_rdR_data(rrd)
    );

    // Behavioural file: captures pins while the strobe is low, commits on its rising edge.
    logic [7:0] fmem [4] = '{default: 8'h00};
    logic [1:0] fa;
    logic [7:0] fd;
    bit         fvalid = 0;
    assign rld = fmem[rla];
    assign rrd = fmem[rra];
    always @(negedge clk) if (wr_en_n === 1'b0) begin fa = wa; fd = wd; fvalid = 1; end
    always @(posedge wr_en_n) if (fvalid) fmem[fa] = fd;

    // Model: each accepted write gets a start cycle (SETUP); everything else follows from it.
    ent_t       wq[$];
    int         t = 0;
    int         last_start = -1000;
    logic [7:0] mm [4] = '{default: 8'h00};
    bit         live = 0;
    logic [7:0] e_rl, e_rr;
    logic       e_ren;

    function automatic int qcount(int tt);
      int n = 0;
      foreach (wq[i]) if (wq[i].acc <= tt && wq[i].start > tt) n++;
      return n;
    endfunction

    function automatic bit inflight(int tt);
      foreach (wq[i]) if (wq[i].start <= tt && tt <= wq[i].start + 1 + S) return 1'b1;
      return 1'b0;
    endfunction

    function automatic logic exp_wen(int tt);
      foreach (wq[i]) if (wq[i].start + 1 <= tt && tt <= wq[i].start + S) return 1'b0;
      return 1'b1;
    endfunction

    function automatic logic [9:0] exp_wad(int tt);
      logic [9:0] v = '0;
      foreach (wq[i]) if (wq[i].start <= tt) v = {wq[i].a, wq[i].d};
      return v;
    endfunction

    function automatic logic [7:0] fwd(logic [1:0] a, int tt);
      logic [7:0] v = mm[a];
      foreach (wq[i])
        if (wq[i].start <= tt && tt <= wq[i].start + 1 + S && wq[i].a == a) v = wq[i].d;
      foreach (wq[i])
        if (wq[i].acc <= tt && wq[i].start > tt && wq[i].a == a) v = wq[i].d;
      return v;
    endfunction

    always @(posedge clk) begin
      ent_t e;
      t++;
      if (reset) begin
        foreach (wq[i])
          if (wq[i].start + 1 <= t - 1 && t - 1 <= wq[i].start + S) mm[wq[i].a] = wq[i].d;
        wq.delete();
        last_start = -1000;
        e_rl = '0; e_rr = '0; e_ren = 1'b1;
        live = 1;
      end else if (live) begin
        e_rl  = fwd(rdL_req_addr, t - 1);
        e_rr  = fwd(rdR_req_addr, t - 1);
        e_ren = 1'b0;
        if (wr_req_valid && qcount(t - 1) < 2) begin
          e.acc   = t;
          e.start = (t + 1 > last_start + 2 + S) ? t + 1 : last_start + 2 + S;
          e.a     = wr_req_addr;
          e.d     = wr_req_data;
          last_start = e.start;
          wq.push_back(e);
        end
        foreach (wq[i]) if (wq[i].start + 1 + S == t) mm[wq[i].a] = wq[i].d;
      end
    end

    always @(negedge clk) if (live) begin
      logic [9:0] wad;
      wad = exp_wad(t);
      chk($sformatf("i%0d.ready", g),   8'(ready),   8'(qcount(t) < 2));
      chk($sformatf("i%0d.busy", g),    8'(busy),    8'(qcount(t) > 0 || inflight(t)));
      chk($sformatf("i%0d.wr_en_n", g), 8'(wr_en_n), 8'(exp_wen(t)));
      chk($sformatf("i%0d.wr_addr", g), 8'(wa),      8'(wad[9:8]));
      chk($sformatf("i%0d.wr_data", g), wd,          wad[7:0]);
      chk($sformatf("i%0d.rdL_q", g),   rdL_q,       e_rl);
      chk($sformatf("i%0d.rdR_q", g),   rdR_q,       e_rr);
      chk($sformatf("i%0d.rdL_en", g),  8'(rdL_en),  8'(e_ren));
      chk($sformatf("i%0d.rdR_en", g),  8'(rdR_en),  8'(e_ren));
      chk($sformatf("i%0d.rdL_addr", g), 8'(rla),    8'(rdL_req_addr));
      chk($sformatf("i%0d.rdR_addr", g), 8'(rra),    8'(rdR_req_addr));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
    tick();
    wr_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((inst[0].busy !== 1'b0 || inst[1].busy !== 1'b0) && n < 100) begin
      tick(); n++;
    end
    chk("idle_wait_in_budget", 8'(n < 100), 8'd1);
  endtask

  initial begin
    int lows, first;
    reset = 1'b1; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    rdL_req_addr = '0; rdR_req_addr = '0;

    // 1: reset values, then idle strobe stays high
    tick(); tick();
    chk("t1_ready", 8'(inst[0].ready), 8'd1);
    chk("t1_busy", 8'(inst[0].busy), 8'd0);
    chk("t1_wen", 8'(inst[0].wr_en_n), 8'd1);
    chk("t1_waddr", 8'(inst[0].wa), 8'd0);
    chk("t1_wdata", inst[0].wd, 8'h00);
    chk("t1_rdLq", inst[0].rdL_q, 8'h00);
    chk("t1_rdRq", inst[0].rdR_q, 8'h00);
    chk("t1_rdLen", 8'(inst[0].rdL_en), 8'd1);
    chk("t1_rdRen", 8'(inst[0].rdR_en), 8'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_idle_wen", 8'(inst[0].wr_en_n), 8'd1);
    end
    chk("t1_rdLen_run", 8'(inst[0].rdL_en), 8'd0);

    // 2: single write, strobe exactly at E+2
    wr(2'd2, 8'hA5);
    chk("t2_wen_E0", 8'(inst[0].wr_en_n), 8'd1);
    tick(); chk("t2_wen_E1", 8'(inst[0].wr_en_n), 8'd1);
    tick(); chk("t2_wen_E2", 8'(inst[0].wr_en_n), 8'd0);
    chk("t2_waddr_E2", 8'(inst[0].wa), 8'd2);
    tick(); chk("t2_wen_E3", 8'(inst[0].wr_en_n), 8'd1);
    wait_idle();
    rdL_req_addr = 2'd2;
    tick(); chk("t2_readback", inst[0].rdL_q, 8'hA5);

    // 3: forwarding from the queue before commit, both ports
    wr(2'd1, 8'h3C);
    rdL_req_addr = 2'd1; rdR_req_addr = 2'd1;
    tick();
    chk("t3_fwdL", inst[0].rdL_q, 8'h3C);
    chk("t3_fwdR", inst[0].rdR_q, 8'h3C);
    chk("t3_not_committed", inst[0].fmem[1], 8'h00);
    wait_idle();

    // 4: back-to-back writes, full queue, newest-entry forwarding
    wr_req_valid = 1'b1; wr_req_addr = 2'd0; wr_req_data = 8'h11; tick();
    wr_req_data = 8'h22; tick();
    wr_req_addr = 2'd3; wr_req_data = 8'h7E; tick();
    wr_req_valid = 1'b0; rdL_req_addr = 2'd0;
    chk("t4_ready_full", 8'(inst[0].ready), 8'd0);
    tick(); chk("t4_fwd_newest", inst[0].rdL_q, 8'h22);
    for (int rel = 4; rel <= 9; rel++) begin
      tick();
      chk("t4_strobe_pattern", 8'(inst[0].wr_en_n), (rel == 5 || rel == 8) ? 8'd0 : 8'd1);
      if (rel == 5) chk("t4_second_data", inst[0].wd, 8'h22);
      if (rel == 8) chk("t4_third_addr", 8'(inst[0].wa), 8'd3);
    end
    wait_idle();
    chk("t4_file_r0", inst[0].fmem[0], 8'h22);
    chk("t4_file_r3", inst[0].fmem[3], 8'h7E);

    // 5: reset during strobe with one entry queued
    wr(2'd2, 8'h55);
    wr_req_valid = 1'b1; wr_req_addr = 2'd1; wr_req_data = 8'h66; tick();
    wr_req_valid = 1'b0;
    tick();
    chk("t5_in_strobe", 8'(inst[0].wr_en_n), 8'd0);
    chk("t5_busy_before", 8'(inst[0].busy), 8'd1);
    reset = 1'b1;
    tick();
    chk("t5_ready", 8'(inst[0].ready), 8'd1);
    chk("t5_busy", 8'(inst[0].busy), 8'd0);
    chk("t5_wen", 8'(inst[0].wr_en_n), 8'd1);
    reset = 1'b0;
    repeat (8) tick();
    chk("t5_queued_dropped", inst[0].fmem[1], 8'h3C);
    chk("t5_inflight_kept", inst[0].fmem[2], 8'h55);

    // 6: three-cycle strobe on the second instance
    wait_idle();
    wr(2'd3, 8'hFF);
    lows = 0; first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (inst[1].wr_en_n === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
    end
    chk("t6_low_cycles", 8'(lows), 8'd3);
    chk("t6_first_low", 8'(first), 8'd2);
    wait_idle();
    rdL_req_addr = 2'd3;
    tick(); chk("t6_readback", inst[1].rdL_q, 8'hFF);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
